// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer: two-byte fetch, then next-PC select with call/return support.
// Optional freeze input enabled by defining STALL_EN.
module pc_sequencer (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] memAddr,
  input  logic [7:0] memData,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  output logic       instrValid,
  input  logic       jump,
  input  logic       branchTaken,
  input  logic       call,
  input  logic       ret,
  input  logic       halt,
  output logic [7:0] retAddrOut,
  output logic       WEtemp,
`ifdef STALL_EN
  input  logic       stall,
`endif
  input  logic [7:0] retAddrIn
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    EXECUTE   = 2'd2,
    HALTED    = 2'd3
  } state_t;

  typedef struct packed {
    logic jmp;
    logic brn;
    logic cal;
    logic rtn;
    logic hlt;
  } ctrl_t;

  state_t     state, state_nx;
  logic [7:0] pc, pc_nx;
  logic [7:0] opcode_nx, operand_nx;
  logic       frz;
  ctrl_t      ctl;

`ifdef STALL_EN
  assign frz = stall;
`else
  assign frz = 1'b0;
`endif

  assign ctl = '{jmp: jump, brn: branchTaken, cal: call, rtn: ret, hlt: halt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH_OP;
      pc      <= 8'h00;
      opcode  <= 8'h00;
      operand <= 8'h00;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      opcode  <= opcode_nx;
      operand <= operand_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    opcode_nx  = opcode;
    operand_nx = operand;
    memAddr    = pc;
    instrValid = 1'b0;
    WEtemp     = 1'b0;
    case (state)
      FETCH_OP: begin
        if (!frz) begin
          opcode_nx = memData;
          state_nx  = FETCH_ARG;
        end
      end
      FETCH_ARG: begin
        memAddr = pc + 8'd1;
        if (!frz) begin
          operand_nx = memData;
          state_nx   = EXECUTE;
        end
      end
      EXECUTE: begin
        // frozen EXECUTE keeps memAddr but withholds valid and the temp write
        if (!frz) begin
          instrValid = 1'b1;
          WEtemp     = ctl.cal & ~ctl.rtn & ~ctl.hlt;
          state_nx   = FETCH_OP;
          if (ctl.hlt)                   state_nx = HALTED;
          else if (ctl.rtn)              pc_nx = retAddrIn;
          else if (ctl.cal)              pc_nx = operand;
          else if (ctl.jmp || ctl.brn)   pc_nx = operand;
          else                           pc_nx = pc + 8'd2;
        end
      end
      default: ;
    endcase
  end

  assign retAddrOut = pc + 8'd2;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle vector table plus reset/stall corner sequences.
module tb_pc_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] memAddr, memData, opcode, operand, retAddrOut, retAddrIn;
  logic       instrValid, jump, branchTaken, call, ret, halt, WEtemp;
`ifdef STALL_EN
  logic       stall;
`endif

  logic [7:0] mem [256];
  assign memData = mem[memAddr];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .memAddr(memAddr), .memData(memData),
    .opcode(opcode), .operand(operand), .instrValid(instrValid),
    .jump(jump), .branchTaken(branchTaken), .call(call), .ret(ret), .halt(halt),
    .retAddrOut(retAddrOut), .WEtemp(WEtemp),
`ifdef STALL_EN
    .stall(stall),
`endif
    .retAddrIn(retAddrIn)
  );

  // ctrl = {halt, ret, call, jump, branchTaken}
  typedef struct {
    logic [4:0] ctrl;
    logic [7:0] rin;
    logic [7:0] addr;
    logic       v;
    logic       we;
    logic [7:0] rout;
    logic [7:0] opc;
    logic [7:0] opr;
  } vec_t;

  vec_t tbl [30];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %02h expected %02h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] c, input logic [7:0] rin);
    {halt, ret, call, jump, branchTaken} = c;
    retAddrIn = rin;
  endtask

  task automatic chk_reset(input int idx);
    chk("rst_addr", idx, memAddr, 8'h00);
    chk("rst_opc",  idx, opcode, 8'h00);
    chk("rst_opr",  idx, operand, 8'h00);
    chk("rst_v",    idx, {7'd0, instrValid}, 8'h00);
    chk("rst_we",   idx, {7'd0, WEtemp}, 8'h00);
    chk("rst_rout", idx, retAddrOut, 8'h02);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h10;
    mem[8'h10] = 8'h44; mem[8'h11] = 8'h40; mem[8'h12] = 8'h66; mem[8'h13] = 8'hFE;
    mem[8'h20] = 8'h88; mem[8'h21] = 8'hFF; mem[8'h40] = 8'h55; mem[8'h41] = 8'h99;
    mem[8'hFE] = 8'h77; mem[8'hFF] = 8'h20;

    tbl[0]  = '{5'h00, 8'h00, 8'h00, 0, 0, 8'h02, 8'h00, 8'h00};
    tbl[1]  = '{5'h00, 8'h00, 8'h01, 0, 0, 8'h02, 8'h11, 8'h00};
    tbl[2]  = '{5'h00, 8'h00, 8'h00, 1, 0, 8'h02, 8'h11, 8'h22};
    tbl[3]  = '{5'h00, 8'h00, 8'h02, 0, 0, 8'h04, 8'h11, 8'h22};
    tbl[4]  = '{5'h00, 8'h00, 8'h03, 0, 0, 8'h04, 8'h33, 8'h22};
    tbl[5]  = '{5'h02, 8'h00, 8'h02, 1, 0, 8'h04, 8'h33, 8'h10};
    tbl[6]  = '{5'h00, 8'h00, 8'h10, 0, 0, 8'h12, 8'h33, 8'h10};
    tbl[7]  = '{5'h00, 8'h00, 8'h11, 0, 0, 8'h12, 8'h44, 8'h10};
    tbl[8]  = '{5'h04, 8'h00, 8'h10, 1, 1, 8'h12, 8'h44, 8'h40};
    tbl[9]  = '{5'h00, 8'h00, 8'h40, 0, 0, 8'h42, 8'h44, 8'h40};
    tbl[10] = '{5'h00, 8'h00, 8'h41, 0, 0, 8'h42, 8'h55, 8'h40};
    tbl[11] = '{5'h0E, 8'h12, 8'h40, 1, 0, 8'h42, 8'h55, 8'h99};
    tbl[12] = '{5'h00, 8'h00, 8'h12, 0, 0, 8'h14, 8'h55, 8'h99};
    tbl[13] = '{5'h00, 8'h00, 8'h13, 0, 0, 8'h14, 8'h66, 8'h99};
    tbl[14] = '{5'h01, 8'h00, 8'h12, 1, 0, 8'h14, 8'h66, 8'hFE};
    tbl[15] = '{5'h00, 8'h00, 8'hFE, 0, 0, 8'h00, 8'h66, 8'hFE};
    tbl[16] = '{5'h00, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h77, 8'hFE};
    tbl[17] = '{5'h04, 8'h00, 8'hFE, 1, 1, 8'h00, 8'h77, 8'h20};
    tbl[18] = '{5'h00, 8'h00, 8'h20, 0, 0, 8'h22, 8'h77, 8'h20};
    tbl[19] = '{5'h00, 8'h00, 8'h21, 0, 0, 8'h22, 8'h88, 8'h20};
    tbl[20] = '{5'h02, 8'h00, 8'h20, 1, 0, 8'h22, 8'h88, 8'hFF};
    tbl[21] = '{5'h00, 8'h00, 8'hFF, 0, 0, 8'h01, 8'h88, 8'hFF};
    tbl[22] = '{5'h00, 8'h00, 8'h00, 0, 0, 8'h01, 8'h20, 8'hFF};
    tbl[23] = '{5'h00, 8'h00, 8'hFF, 1, 0, 8'h01, 8'h20, 8'h11};
    tbl[24] = '{5'h00, 8'h00, 8'h01, 0, 0, 8'h03, 8'h20, 8'h11};
    tbl[25] = '{5'h00, 8'h00, 8'h02, 0, 0, 8'h03, 8'h22, 8'h11};
    tbl[26] = '{5'h14, 8'h00, 8'h01, 1, 0, 8'h03, 8'h22, 8'h33};
    tbl[27] = '{5'h02, 8'h00, 8'h01, 0, 0, 8'h03, 8'h22, 8'h33};
    tbl[28] = '{5'h08, 8'h55, 8'h01, 0, 0, 8'h03, 8'h22, 8'h33};
    tbl[29] = '{5'h04, 8'h00, 8'h01, 0, 0, 8'h03, 8'h22, 8'h33};

    drive(5'h00, 8'h00);
`ifdef STALL_EN
    stall = 1'b0;
`endif
    reset = 1'b1;
    #2;
    chk_reset(0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].ctrl, tbl[i].rin);
      @(negedge clk);
      chk("addr", i, memAddr, tbl[i].addr);
      chk("valid", i, {7'd0, instrValid}, {7'd0, tbl[i].v});
      chk("we", i, {7'd0, WEtemp}, {7'd0, tbl[i].we});
      chk("rout", i, retAddrOut, tbl[i].rout);
      chk("opc", i, opcode, tbl[i].opc);
      chk("opr", i, operand, tbl[i].opr);
      @(posedge clk); #1;
    end
    drive(5'h00, 8'h00);

    // reset during FETCH_ARG
    do_reset();
    @(posedge clk); #1;
    chk("fa_addr", 100, memAddr, 8'h01);
    reset = 1'b1;
    #1;
    chk_reset(101);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("fa_restart", 102, memAddr, 8'h00);
    @(posedge clk); #1;
    chk("fa_opc", 103, opcode, 8'h11);

    // reset during EXECUTE with call high
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    call = 1'b1;
    #1;
    chk("ex_we", 110, {7'd0, WEtemp}, 8'h01);
    chk("ex_valid", 110, {7'd0, instrValid}, 8'h01);
    reset = 1'b1;
    #1;
    chk_reset(111);
    call = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ex_restart", 112, memAddr, 8'h00);

`ifdef STALL_EN
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    call = 1'b1;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_valid", 120 + k, {7'd0, instrValid}, 8'h00);
      chk("st_we", 120 + k, {7'd0, WEtemp}, 8'h00);
      chk("st_addr", 120 + k, memAddr, 8'h00);
      chk("st_rout", 120 + k, retAddrOut, 8'h02);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    #1;
    chk("st_rel_valid", 130, {7'd0, instrValid}, 8'h01);
    chk("st_rel_we", 130, {7'd0, WEtemp}, 8'h01);
    @(posedge clk); #1;
    call = 1'b0;
    chk("st_target", 131, memAddr, 8'h22);
    chk("st_we_off", 131, {7'd0, WEtemp}, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
